sram_fill_loader: RTL
=====================

# sram_fill_loader

Single-clock port sequencer that drives one port of the core's dual-port synchronous RAMs (8x1K default). After reset, or on request, it clears every location to a fill value. It then accepts an auto-incrementing byte stream from the ROM/NVRAM download path and otherwise passes host (CPU/video) accesses straight through. It owns the RAM port's address, data, enable and write lines; the RAM's registered read data returns through it.

## Interface

Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 10, RAM address width; depth = 2**ADDR_WIDTH
- FILL_VALUE, 0, word written to every location during clear

Ports:
- clk  in  1  single clock; reset is synchronous and active-high
- reset  in  1  synchronous, active-high
- clear_req  in  1  single-cycle pulse; starts or restarts a full clear
- ld_valid  in  1  loader beat valid
- ld_ready  out  1  loader beat accepted when ld_valid & ld_ready
- ld_first  in  1  qualifies beat as first of a load; beat written to address 0
- ld_data  in  DATA_WIDTH  loader word
- ld_wrap  out  1  sticky: load address counter wrapped past depth-1
- host_cen  in  1  host access request
- host_we  in  1  host write (with host_cen)
- host_addr  in  ADDR_WIDTH  host address
- host_data  in  DATA_WIDTH  host write data
- host_q  out  DATA_WIDTH  read data, equals ram_q
- host_rvalid  out  1  host_q holds data of the read granted on the previous cycle
- busy  out  1  clear in progress
- done  out  1  one-cycle pulse on clear completion
- ram_addr, ram_data  out  ADDR_WIDTH / DATA_WIDTH  to RAM port
- ram_cen, ram_we  out  1  to RAM port
- ram_q  in  DATA_WIDTH  RAM port registered output

## Operation

- States: CLEAR and IDLE.
- Reset: state=CLEAR; clr_cnt=0; ld_cnt=0; ld_wrap=0. While reset is high: ram_cen=0, ram_we=0, busy=1, done=0, ld_ready=0, host_rvalid=0.
- CLEAR: each cycle ram_cen=1, ram_we=1, ram_addr=clr_cnt, ram_data=FILL_VALUE; clr_cnt increments. After the write to depth-1, go to IDLE and pulse done for one cycle.
- CLEAR blocking: host accesses are dropped and host_rvalid=0; ld_ready=0.
- clear_req in CLEAR restarts clr_cnt at 0. clear_req in IDLE enters CLEAR next cycle. In that cycle ld_ready=0 and the host access is dropped.
- IDLE, loader: ld_ready=1 unless clear_req is asserted that cycle.
- Accepted beat: ram_we=1, ram_cen=1, ram_data=ld_data, ram_addr = 0 if ld_first, else ld_cnt. ld_cnt becomes written address+1, mod depth.
- ld_first also clears ld_wrap. A non-first write to depth-1 sets ld_wrap.
- IDLE, host: if no loader beat is accepted, ram_* = host_* (cen, we, addr, data). A loader beat takes priority: a host access in the same cycle is dropped.
- host_q = ram_q combinationally.
- Counter arithmetic is unsigned ADDR_WIDTH bits with natural wrap.

## Timing

- Clear takes exactly 2**ADDR_WIDTH cycles. The first write is in the first cycle with reset low (address 0).
- done=1 and busy=0 in cycle 2**ADDR_WIDTH after reset release. ld_ready may be 1 in that same cycle.
- Host read latency: 1 cycle. host_rvalid is registered, =1 the cycle after a granted host read (host_cen & !host_we).
- Host and loader write latency: 0 cycles to the RAM port; the RAM commits on the same edge.
- Reset mid-clear or mid-load aborts the operation; the clear restarts from address 0.
- A loader beat's ld_data must be stable only during its accept cycle.

## Test plan

- ADDR_WIDTH=4, FILL_VALUE=8'hA5, reset for 3 cycles, then release:
  - ram_we is high for 16 cycles at addresses 0..15.
  - done pulses in cycle 16; busy falls in the same cycle.
  - Host reads of every address return 8'hA5 with host_rvalid one cycle after each read.
- Loader, 5 beats 8'h10..8'h14 with the first carrying ld_first, ld_valid toggled every other cycle:
  - Addresses 0..4 hold 8'h10..8'h14.
  - ld_wrap=0.
- Loader, 17 beats after ld_first on a depth-16 RAM:
  - Beat 17 writes address 0.
  - ld_wrap=1 from the cycle after address 15 is written.
  - A further ld_first beat clears ld_wrap.
- Simultaneous ld_valid and a host write to address 3:
  - The loader beat is written; address 3 is unchanged.
  - host_rvalid=0 for the dropped access.
- clear_req at clr_cnt=9:
  - The next write goes to address 0.
  - done comes 16 cycles after the restart.
  - Host write attempts during busy leave the memory unchanged.
- reset asserted in the middle of a load:
  - ld_cnt=0 and ld_wrap=0.
  - A full 16-cycle clear reruns.
  - Reading loaded addresses afterwards returns FILL_VALUE.

Source files
------------

// File: rtl/sram_fill_loader.sv
// rtl/sram_fill_loader.sv - RAM port sequencer: fill-clear, streaming loader, host pass-through
module sram_fill_loader #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic                  ld_first,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_wrap,
    input  logic                  host_cen,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data,
    output logic [DATA_WIDTH-1:0] host_q,
    output logic                  host_rvalid,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cen,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_WIDTH-1:0] ld_cnt_q, ld_cnt_d;
    logic                  ld_wrap_q, ld_wrap_d;
    logic                  done_q, done_d;
    logic                  rvalid_q, rvalid_d;
    logic [ADDR_WIDTH-1:0] ld_addr;

    // A beat's write address: first beats restart at 0, others continue from the counter
    assign ld_addr  = ld_first ? '0 : ld_cnt_q;
    assign ld_ready = !reset && (state_q == ST_IDLE) && !clear_req;

    // Next-state and RAM port mux: clear writes fill, loader beats beat the host, host passes through
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ld_cnt_d  = ld_cnt_q;
        ld_wrap_d = ld_wrap_q;
        done_d    = 1'b0;
        rvalid_d  = 1'b0;
        ram_cen   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_data  = '0;
        case (state_q)
            ST_CLEAR: begin
                ram_cen  = 1'b1;
                ram_we   = 1'b1;
                ram_addr = clr_cnt_q;
                ram_data = FILL_VALUE;
                if (clear_req) begin
                    clr_cnt_d = '0;
                end else if (clr_cnt_q == ADDR_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_ONE;
                end
            end
            default: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (ld_valid) begin
                    ram_cen  = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = ld_addr;
                    ram_data = ld_data;
                    ld_cnt_d = ld_addr + ADDR_ONE;
                    if (ld_first) begin
                        ld_wrap_d = 1'b0;
                    end else if (ld_addr == ADDR_LAST) begin
                        ld_wrap_d = 1'b1;
                    end
                end else begin
                    ram_cen  = host_cen;
                    ram_we   = host_we;
                    ram_addr = host_addr;
                    ram_data = host_data;
                    rvalid_d = host_cen && !host_we;
                end
            end
        endcase
        if (reset) begin
            ram_cen = 1'b0;
            ram_we  = 1'b0;
        end
    end

    // State and counter registers; reset restarts the clear from address 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ld_cnt_q  <= '0;
            ld_wrap_q <= 1'b0;
            done_q    <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ld_cnt_q  <= ld_cnt_d;
            ld_wrap_q <= ld_wrap_d;
            done_q    <= done_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign busy        = reset || (state_q == ST_CLEAR);
    assign done        = done_q && !reset;
    assign host_rvalid = rvalid_q && !reset;
    assign host_q      = ram_q;
    assign ld_wrap     = ld_wrap_q;

endmodule
